// File: rtl/fp_add_arbiter.sv
// Round-robin sequencer sharing one fixed-latency FP adder among N_REQ requesters.
// Define FPADD_ARB_ERR_CNT_EN to add err_count, a saturating count of nonzero statuses.
module fp_add_arbiter #(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 16
) (
    input  logic                clock_100kHz,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [32*N_REQ-1:0] req_op_a,
    input  logic [32*N_REQ-1:0] req_op_b,
    output logic [N_REQ-1:0]    rsp_valid,
    input  logic [N_REQ-1:0]    rsp_ready,
    output logic [31:0]         rsp_data,
    output logic [3:0]          rsp_status,
    output logic [31:0]         fpu_op_a,
    output logic [31:0]         fpu_op_b,
    input  logic [31:0]         fpu_data_in,
    input  logic [3:0]          fpu_status_in,
`ifdef FPADD_ARB_ERR_CNT_EN
    output logic [15:0]         err_count,
`endif
    output logic                busy
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        r_state;
    logic [IW-1:0] r_rr_ptr;
    logic [IW-1:0] r_grant;
    logic [CW-1:0] r_cnt;
    logic [IW-1:0] w_g;
    logic [IW-1:0] w_next;
    logic [IW:0]   w_k;
    logic          w_any;

    // Search starts at the pointer and wraps, so the last winner goes last.
    always_comb begin
        w_any = 1'b0;
        w_g   = '0;
        w_k   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_k = {1'b0, r_rr_ptr} + (IW+1)'(i);
            if (w_k >= (IW+1)'(N_REQ))
                w_k = w_k - (IW+1)'(N_REQ);
            if (!w_any && req_valid[w_k[IW-1:0]]) begin
                w_any = 1'b1;
                w_g   = w_k[IW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (r_state == IDLE && w_any)
            req_ready[w_g] = 1'b1;
        if (r_state == RESP)
            rsp_valid[r_grant] = 1'b1;
    end

    assign busy   = (r_state != IDLE);
    assign w_next = (r_grant == IW'(N_REQ - 1)) ? '0 : r_grant + IW'(1);

    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_grant    <= '0;
            r_cnt      <= '0;
            fpu_op_a   <= '0;
            fpu_op_b   <= '0;
            rsp_data   <= '0;
            rsp_status <= '0;
`ifdef FPADD_ARB_ERR_CNT_EN
            err_count  <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        fpu_op_a <= req_op_a[32*w_g +: 32];
                        fpu_op_b <= req_op_b[32*w_g +: 32];
                        r_grant  <= w_g;
                        r_cnt    <= CW'(LATENCY - 1);
                        r_state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        rsp_data   <= fpu_data_in;
                        rsp_status <= fpu_status_in;
                        r_state    <= RESP;
`ifdef FPADD_ARB_ERR_CNT_EN
                        if (fpu_status_in != 4'd0 && err_count != 16'hFFFF)
                            err_count <= err_count + 16'd1;
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready[r_grant]) begin
                        r_rr_ptr <= w_next;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: stub XOR adder, transaction-level model, directed scenarios.
module tb_fp_add_arbiter;
    localparam int N = 4;
    localparam int L = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   rsp_ready = '0;
    logic [32*N-1:0] op_a = '0;
    logic [32*N-1:0] op_b = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [31:0]    rsp_data;
    logic [3:0]     rsp_status;
    logic [31:0]    fpu_a;
    logic [31:0]    fpu_b;
    logic [31:0]    fdat;
    logic [3:0]     fst;
    logic           busy;
`ifdef FPADD_ARB_ERR_CNT_EN
    logic [15:0]    err_count;
`endif

    fp_add_arbiter #(.N_REQ(N), .LATENCY(L)) dut (
        .clock_100kHz (clk),
        .reset        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op_a     (op_a),
        .req_op_b     (op_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_status   (rsp_status),
        .fpu_op_a     (fpu_a),
        .fpu_op_b     (fpu_b),
        .fpu_data_in  (fdat),
        .fpu_status_in(fst),
`ifdef FPADD_ARB_ERR_CNT_EN
        .err_count    (err_count),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Stub adder: XOR result and A's low nibble, 10 cycles late.
    logic [35:0] dl [10];
    always @(posedge clk) begin
        dl[0] <= {fpu_a[3:0], fpu_a ^ fpu_b};
        for (int i = 1; i < 10; i++)
            dl[i] <= dl[i-1];
    end
    assign fdat = dl[9][31:0];
    assign fst  = dl[9][35:32];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit cmp_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++)
            if (v[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    // Model: m_t = -1 when idle, else edges since accept; L means response pending.
    int          m_t = -1;
    int          m_ptr = 0;
    int          m_grant = 0;
    int          m_err = 0;
    int          m_pick;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic [31:0] m_data = '0;
    logic [3:0]  m_st = '0;

    always_comb m_pick = pick(req_valid, m_ptr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t <= -1; m_ptr <= 0; m_grant <= 0; m_err <= 0;
            m_a <= '0; m_b <= '0; m_data <= '0; m_st <= '0;
        end else if (m_t < 0) begin
            if (m_pick >= 0) begin
                m_grant <= m_pick;
                m_a <= op_a[32*m_pick +: 32];
                m_b <= op_b[32*m_pick +: 32];
                m_t <= 0;
            end
        end else if (m_t < L) begin
            m_t <= m_t + 1;
            if (m_t == L - 1) begin
                m_data <= m_a ^ m_b;
                m_st <= m_a[3:0];
                if (m_a[3:0] != 4'd0 && m_err < 65535)
                    m_err <= m_err + 1;
            end
        end else if (rsp_ready[m_grant]) begin
            m_t <= -1;
            m_ptr <= (m_grant + 1) % N;
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] e_rr;
        logic [N-1:0] e_rv;
        if (cmp_on) begin
            e_rr = '0;
            e_rv = '0;
            if (m_t < 0 && m_pick >= 0) e_rr[m_pick] = 1'b1;
            if (m_t == L) e_rv[m_grant] = 1'b1;
            chk("req_ready", req_ready, e_rr);
            chk("rsp_valid", rsp_valid, e_rv);
            chk("busy", busy, m_t >= 0);
            chk("rsp_data", rsp_data, m_data);
            chk("rsp_status", rsp_status, m_st);
            chk("fpu_op_a", fpu_a, m_a);
            chk("fpu_op_b", fpu_b, m_b);
`ifdef FPADD_ARB_ERR_CNT_EN
            chk("err_count", err_count, m_err);
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = '0;
        op_a = '0;
        op_b = '0;
        rst_n = 1'b0;
        #1;
        cmp_on = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_fpu_a", fpu_a, 0);
        chk("rst_fpu_b", fpu_b, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_status", rsp_status, 0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic wait_rsp(input int idx);
        for (int k = 0; k < 60; k++) begin
            if (rsp_valid[idx]) break;
            tick(1);
        end
        chk("rsp_timeout", rsp_valid[idx], 1);
    endtask

    task automatic txn(input int idx, input logic [31:0] a, input logic [31:0] b);
        op_a[32*idx +: 32] = a;
        op_b[32*idx +: 32] = b;
        req_valid = '0;
        req_valid[idx] = 1'b1;
        rsp_ready = '0;
        rsp_ready[idx] = 1'b1;
        #1;
        for (int k = 0; k < 60; k++) begin
            if (req_ready[idx]) break;
            tick(1);
        end
        chk("txn_accept", req_ready[idx], 1);
        tick(1);
        req_valid = '0;
        wait_rsp(idx);
        chk("txn_data", rsp_data, a ^ b);
        tick(1);
        rsp_ready = '0;
    endtask

    logic [31:0] a_tab [N];
    logic [31:0] b_tab [N];
    int          gq[$];
    int          cq[$];
    int          exp_g [5];
    int          c0;
    int          idx;
    int          nrsp;
    logic [31:0] d;
    bit          seen;

    initial begin
        a_tab = '{32'h3E00_0000, 32'h1234_5672, 32'h0F0F_0F01, 32'hA5A5_0003};
        b_tab = '{32'h4000_0000, 32'h0000_FFFF, 32'hF0F0_0000, 32'h5A5A_5A5A};
        exp_g = '{0, 1, 2, 3, 0};
        @(posedge clk);
        #1;
        do_reset();

        // Single request from requester 0.
        op_a[31:0] = 32'h3E00_0000;
        op_b[31:0] = 32'h4000_0000;
        req_valid = 4'b0001;
        #1;
        chk("t1_req_ready", req_ready, 4'b0001);
        c0 = cyc;
        tick(1);
        req_valid = '0;
        for (int k = 0; k < 40; k++) begin
            if (rsp_valid != 0) break;
            chk("t1_busy", busy, 1);
            tick(1);
        end
        chk("t1_latency", cyc - c0, 17);
        chk("t1_rsp_valid", rsp_valid, 4'b0001);
        chk("t1_rsp_data", rsp_data, 32'h7E00_0000);
        chk("t1_rsp_status", rsp_status, 4'h0);
        chk("t1_busy_resp", busy, 1);
        rsp_ready = 4'b0001;
        tick(1);
        chk("t1_idle", busy, 0);
        rsp_ready = '0;
        tick(3);
        chk("t1_stay_idle", busy, 0);

        // All four requesters continuously valid.
        do_reset();
        for (int i = 0; i < N; i++) begin
            op_a[32*i +: 32] = a_tab[i];
            op_b[32*i +: 32] = b_tab[i];
        end
        rsp_ready = 4'hF;
        req_valid = 4'hF;
        #1;
        nrsp = 0;
        for (int k = 0; k < 150 && gq.size() < 5; k++) begin
            if (req_ready != 0) begin
                gq.push_back($clog2(req_ready));
                cq.push_back(cyc);
            end
            if (rsp_valid != 0) begin
                idx = $clog2(rsp_valid);
                chk("rr_data", rsp_data, a_tab[idx] ^ b_tab[idx]);
                nrsp++;
            end
            if (gq.size() < 5) tick(1);
        end
        req_valid = '0;
        chk("rr_grants", gq.size(), 5);
        chk("rr_rsps", nrsp, 4);
        for (int k = 0; k < gq.size() && k < 5; k++)
            chk("rr_order", gq[k], exp_g[k]);
        for (int k = 1; k < cq.size(); k++)
            chk("rr_spacing", cq[k] - cq[k-1], 18);
        tick(2);

        // Backpressure on requester 2.
        do_reset();
        op_a[95:64] = 32'h4000_0005;
        op_b[95:64] = 32'h3E00_0000;
        req_valid = 4'b0100;
        rsp_ready = 4'b1011;
        #1;
        chk("bp_req_ready", req_ready, 4'b0100);
        tick(1);
        req_valid = 4'hF;
        wait_rsp(2);
        d = rsp_data;
        chk("bp_data", d, 32'h7E00_0005);
        for (int k = 0; k < 5; k++) begin
            tick(1);
            chk("bp_hold_valid", rsp_valid, 4'b0100);
            chk("bp_hold_data", rsp_data, d);
            chk("bp_no_ready", req_ready, 0);
        end
        rsp_ready = 4'hF;
        #1;
        chk("bp_ready_cycle", req_ready, 0);
        tick(1);
        chk("bp_next_grant", req_ready, 4'b1000);
        req_valid = '0;
        rsp_ready = '0;
        tick(1);

        // Operand stability while busy.
        do_reset();
        op_a[31:0] = 32'h1111_1113;
        op_b[31:0] = 32'h2222_2222;
        req_valid = 4'b0001;
        tick(1);
        req_valid = '0;
        tick(3);
        op_a[31:0] = 32'hDEAD_BEEF;
        for (int k = 0; k < 40; k++) begin
            if (rsp_valid != 0) break;
            chk("st_fpu_a", fpu_a, 32'h1111_1113);
            tick(1);
        end
        chk("st_rsp_valid", rsp_valid, 4'b0001);
        chk("st_data", rsp_data, 32'h3333_3331);
        chk("st_status", rsp_status, 4'h3);
        rsp_ready = 4'b0001;
        tick(1);
        rsp_ready = '0;

        // Reset in the middle of BUSY.
        do_reset();
        txn(1, 32'h0000_00F0, 32'h0000_000F);
        op_a[127:96] = 32'h7777_0007;
        req_valid = 4'b1000;
        #1;
        chk("mr_grant3", req_ready, 4'b1000);
        tick(1);
        req_valid = '0;
        tick(7);
        chk("mr_busy_before", busy, 1);
        do_reset();
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (rsp_valid != 0) seen = 1'b1;
            tick(1);
        end
        chk("mr_no_rsp", seen, 0);
        req_valid = 4'hF;
        #1;
        chk("mr_grant0", req_ready, 4'b0001);
        req_valid = '0;
        tick(1);

`ifdef FPADD_ARB_ERR_CNT_EN
        do_reset();
        chk("err_reset", err_count, 0);
        txn(0, 32'h3E00_0001, 32'h1);
        txn(0, 32'h3E00_0000, 32'h2);
        txn(0, 32'h3E00_0007, 32'h3);
        txn(0, 32'h4000_0000, 32'h4);
        txn(0, 32'h4000_000F, 32'h5);
        chk("err_count3", err_count, 16'd3);
`endif

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
